lighthouse_sample_arbiter: RTL and testbench
============================================

# lighthouse_sample_arbiter

Collects the per-sensor 32-bit measurement words produced by the lighthouse sensor channels and serialises them onto one valid/ready stream for the downstream SPI framer or FIFO. Each sensor has a one-deep holding slot. A round-robin scheduler drains the slots fairly. Overruns, where a sensor produces a new word before its old one was taken, are counted rather than silently lost.

## Interface
- NUMBER_OF_SENSORS, 4: number of sensor channels (1–16).
- OVR_WIDTH, 16: width of the saturating overrun counter.
- clock  in  1: system clock, 50 MHz.
- reset_n  in  1: asynchronous, active-low reset.
- enable_i  in  1: accept new samples when 1.
- sample_strobe_i  in  NUMBER_OF_SENSORS: one-cycle pulse per sensor marking a new word on its slice of sensor_data_i.
- sensor_data_i  in  32*NUMBER_OF_SENSORS: sensor k's word is at [32k+31:32k]. Fields: 31 lighthouse_id, 30 axis, 29 valid, 28:19 sensor_id, 18:0 duration.
- out_valid_o  out  1: out_data_o is valid.
- out_ready_i  in  1: consumer accepts the word. A transfer happens when valid and ready are both high.
- out_data_o  out  32: forwarded sensor word, unmodified.
- out_sensor_o  out  4: index of the source slot.
- pending_o  out  NUMBER_OF_SENSORS: slot-occupied flags.
- overrun_flags_o  out  NUMBER_OF_SENSORS: sticky per-sensor overrun flags.
- overrun_count_o  out  OVR_WIDTH: total overruns, saturating at all-ones.
- clear_i  in  1: synchronous clear of the overrun flags and counter.

## Operation
- **Capture.** A sample is captured when sample_strobe_i[k], enable_i and bit 29 of the sensor word are all 1. The word is written to hold[k] and pending[k] is set.
  - A strobe whose valid bit is 0 is ignored.
  - A strobe while enable_i=0 is ignored.
- **Overrun.** If a capture hits a slot with pending[k]=1 and that slot is not being unloaded in the same cycle:
  - hold[k] is overwritten with the newest word.
  - overrun_flags_o[k] is set.
  - overrun_count_o increments, saturating at all-ones.
- **Capture and unload on the same slot in one cycle.** The old word moves to the output register and the new word is latched. pending[k] stays 1. This is not an overrun.
- **Output register load.** The output register loads when out_valid_o=0 or a transfer occurs this cycle, and some pending bit is set.
  - The slot is picked round-robin, searching from last_grant+1 modulo NUMBER_OF_SENSORS.
  - On load: out_data_o←hold[sel], out_sensor_o←sel, out_valid_o←1, pending[sel] is cleared, last_grant←sel.
- **Idle.** If a transfer occurs and nothing is pending, out_valid_o←0.
- **Stall.** While out_valid_o=1 and out_ready_i=0, out_data_o and out_sensor_o hold stable. No slot is unloaded.
- **Disable.** Deasserting enable_i blocks new captures only. Pending words still drain.
- **clear_i.** Clears overrun_flags_o and overrun_count_o. If a capture overruns in the same cycle as clear_i, clear wins, and that cycle's overrun is not counted.
- **Reset.** Every output is 0: out_valid_o, out_data_o, out_sensor_o, pending_o, overrun_flags_o, overrun_count_o. Internal state: hold[] is 0 and last_grant is NUMBER_OF_SENSORS-1, so sensor 0 has first priority.
  - Reset mid-transfer discards all held and presented words.

## Timing
- The strobe is sampled at edge t, so pending[k] is high after edge t.
- The output register is loaded at edge t+1, so out_valid_o is high after t+1. Latency is 2 cycles when the output register is free.
- Sustained throughput is one word per cycle when out_ready_i=1.
- Four simultaneous strobes drain in 4 consecutive cycles.
- The arbiter is purely combinational on registered pending/last_grant. There is no combinational path from out_ready_i to out_valid_o.

## Structure
- A shared package lighthouse_pkg holds:
  - field constants LH_ID_BIT=31, AXIS_BIT=30, VALID_BIT=29, SENSOR_ID_MSB=28, SENSOR_ID_LSB=19, DURATION_MSB=18;
  - SENSOR_WORD_WIDTH=32.
- Sub-module rr_arbiter(NUMBER_OF_SENSORS): inputs request vector and last_grant; outputs one-hot grant, grant index and any.
- Holding slots and counters stay in the top module.

## Test plan
- **Single sample.** Strobe sensor 2 with 0x2000_1234, ready=1. Expect out_valid_o high for exactly 1 cycle, 2 cycles after the strobe, with out_data_o=0x20001234 and out_sensor_o=2.
- **Four simultaneous samples.** All four strobe in the same cycle with words 0x2000_0000+k, ready=1. Expect out_sensor_o sequence 0,1,2,3 on consecutive cycles, then out_valid_o=0.
- **Stall and overrun.** Hold ready=0. Strobe sensor 1 with A=0x2000_000A, then B=0x2000_000B, then C=0x2000_000C, one strobe per cycle.
  - A is presented and held stable.
  - C overwrites B: overrun_count_o=1 and overrun_flags_o=4'b0010.
  - Raise ready. Expect transfers A then C.
- **Filtered strobes.** Strobe with bit 29=0 (0x0000_0055), and a strobe while enable_i=0. Expect no pending bit set, no output and no count change.
- **Same-cycle unload and capture.** Sensor 0 is pending and being unloaded by a transfer while a new strobe hits sensor 0. Expect pending_o[0] to remain 1, overrun_count_o unchanged, and the new word output on a later cycle.
- **Reset mid-operation.** Pulse reset_n low with 3 slots pending and out_valid_o=1. Expect all outputs 0 immediately. The next strobe on sensor 3 is output 2 cycles later.

Source files
------------

// File: rtl/lighthouse_sample_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lighthouse_pkg
// Brief   : Shared field layout and types for lighthouse sensor words.
// Revision: 1.0 - initial release
// ============================================================================
package lighthouse_pkg;

    localparam int SENSOR_WORD_WIDTH = 32;
    localparam int LH_ID_BIT         = 31;
    localparam int AXIS_BIT          = 30;
    localparam int VALID_BIT         = 29;
    localparam int SENSOR_ID_MSB     = 28;
    localparam int SENSOR_ID_LSB     = 19;
    localparam int DURATION_MSB      = 18;
    localparam int SENSOR_IDX_WIDTH  = 4;

    typedef logic [SENSOR_WORD_WIDTH-1:0] sensor_word_t;
    typedef logic [SENSOR_IDX_WIDTH-1:0]  sensor_idx_t;

    function automatic logic word_is_valid(input sensor_word_t word);
        return word[VALID_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lighthouse_sample_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : lighthouse_sample_arbiter_if
// Brief   : Sensor strobe/data inputs plus the serialised valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
interface lighthouse_sample_arbiter_if #(
    parameter int NUMBER_OF_SENSORS = 4
);
    import lighthouse_pkg::*;

    logic [NUMBER_OF_SENSORS-1:0]                   sample_strobe_i;
    logic [SENSOR_WORD_WIDTH*NUMBER_OF_SENSORS-1:0] sensor_data_i;
    logic                                           out_valid_o;
    logic                                           out_ready_i;
    sensor_word_t                                   out_data_o;
    sensor_idx_t                                    out_sensor_o;

    // The arbiter sources the output stream.
    modport master (
        input  sample_strobe_i,
        input  sensor_data_i,
        input  out_ready_i,
        output out_valid_o,
        output out_data_o,
        output out_sensor_o
    );

    modport slave (
        output sample_strobe_i,
        output sensor_data_i,
        output out_ready_i,
        input  out_valid_o,
        input  out_data_o,
        input  out_sensor_o
    );

endinterface
`default_nettype wire

// File: rtl/lighthouse_sample_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin pick starting one past the previous grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import lighthouse_pkg::*;
#(
    parameter int NUMBER_OF_SENSORS = 4
) (
    input  logic [NUMBER_OF_SENSORS-1:0] request,
    input  sensor_idx_t                  last_grant,
    output logic [NUMBER_OF_SENSORS-1:0] grant,
    output sensor_idx_t                  grant_index,
    output logic                         any
);

    localparam logic [4:0] c_count = 5'(NUMBER_OF_SENSORS);

    logic [15:0] w_req_pad;
    logic [4:0]  w_slot;
    logic        w_found;

    assign w_req_pad = 16'(request);

    always_comb begin
        w_found     = 1'b0;
        w_slot      = '0;
        grant_index = '0;
        for (int off = 1; off <= NUMBER_OF_SENSORS; off++) begin
            w_slot = {1'b0, last_grant} + 5'(off);
            if (w_slot >= c_count) begin
                w_slot = w_slot - c_count;
            end
            if (!w_found && w_req_pad[w_slot[3:0]]) begin
                w_found     = 1'b1;
                grant_index = w_slot[3:0];
            end
        end
    end

    generate
        for (genvar k = 0; k < NUMBER_OF_SENSORS; k++) begin : g_grant
            assign grant[k] = w_found && (grant_index == sensor_idx_t'(k));
        end
    endgenerate

    assign any = w_found;

endmodule
`default_nettype wire

// File: rtl/lighthouse_sample_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lighthouse_sample_arbiter
// Brief   : One-deep per-sensor slots drained round-robin onto a valid/ready
//           stream, with sticky overrun flags and a saturating overrun count.
// Revision: 1.0 - initial release
// ============================================================================
module lighthouse_sample_arbiter
    import lighthouse_pkg::*;
#(
    parameter int NUMBER_OF_SENSORS = 4,
    parameter int OVR_WIDTH         = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable_i,
    input  logic                           clear_i,
    lighthouse_sample_arbiter_if.master    bus,
    output logic [NUMBER_OF_SENSORS-1:0]   pending_o,
    output logic [NUMBER_OF_SENSORS-1:0]   overrun_flags_o,
    output logic [OVR_WIDTH-1:0]           overrun_count_o
);

    localparam int c_sum_width = OVR_WIDTH + 5;

    sensor_word_t                 r_hold [NUMBER_OF_SENSORS];
    logic [NUMBER_OF_SENSORS-1:0] r_pending;
    logic [NUMBER_OF_SENSORS-1:0] r_flags;
    logic [OVR_WIDTH-1:0]         r_count;
    sensor_idx_t                  r_last_grant;
    logic                         r_out_valid;
    sensor_word_t                 r_out_data;
    sensor_idx_t                  r_out_sensor;

    logic                         w_xfer;
    logic                         w_load;
    logic                         w_any;
    sensor_idx_t                  w_grant_index;
    logic [NUMBER_OF_SENSORS-1:0] w_grant;
    logic [NUMBER_OF_SENSORS-1:0] w_capture;
    logic [NUMBER_OF_SENSORS-1:0] w_unload;
    logic [NUMBER_OF_SENSORS-1:0] w_overrun;
    logic [4:0]                   w_overrun_num;
    sensor_word_t                 w_sel_data;
    logic [c_sum_width-1:0]       w_count_sum;
    logic [OVR_WIDTH-1:0]         w_count_next;

    rr_arbiter #(
        .NUMBER_OF_SENSORS (NUMBER_OF_SENSORS)
    ) u_rr_arbiter (
        .request     (r_pending),
        .last_grant  (r_last_grant),
        .grant       (w_grant),
        .grant_index (w_grant_index),
        .any         (w_any)
    );

    assign w_xfer   = r_out_valid & bus.out_ready_i;
    assign w_load   = (~r_out_valid | w_xfer) & w_any;
    assign w_unload = w_load ? w_grant : '0;

    generate
        for (genvar k = 0; k < NUMBER_OF_SENSORS; k++) begin : g_capture
            assign w_capture[k] = bus.sample_strobe_i[k] & enable_i &
                                  word_is_valid(bus.sensor_data_i[k*SENSOR_WORD_WIDTH +: SENSOR_WORD_WIDTH]);
        end
    endgenerate

    // A slot being unloaded this cycle can take a new word without loss.
    assign w_overrun = w_capture & r_pending & ~w_unload;

    always_comb begin
        w_sel_data    = '0;
        w_overrun_num = '0;
        for (int k = 0; k < NUMBER_OF_SENSORS; k++) begin
            if (w_grant[k]) begin
                w_sel_data = w_sel_data | r_hold[k];
            end
            w_overrun_num = w_overrun_num + {4'b0, w_overrun[k]};
        end
    end

    assign w_count_sum  = {5'b0, r_count} + c_sum_width'(w_overrun_num);
    assign w_count_next = (w_count_sum[c_sum_width-1:OVR_WIDTH] != '0) ? '1
                                                                       : w_count_sum[OVR_WIDTH-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUMBER_OF_SENSORS; k++) begin
                r_hold[k] <= '0;
            end
            r_pending    <= '0;
            r_flags      <= '0;
            r_count      <= '0;
            r_last_grant <= sensor_idx_t'(NUMBER_OF_SENSORS - 1);
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sensor <= '0;
        end else begin
            for (int k = 0; k < NUMBER_OF_SENSORS; k++) begin
                if (w_capture[k]) begin
                    r_hold[k] <= bus.sensor_data_i[k*SENSOR_WORD_WIDTH +: SENSOR_WORD_WIDTH];
                end
            end
            r_pending <= (r_pending & ~w_unload) | w_capture;

            if (clear_i) begin
                r_flags <= '0;
                r_count <= '0;
            end else begin
                r_flags <= r_flags | w_overrun;
                r_count <= w_count_next;
            end

            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_sel_data;
                r_out_sensor <= w_grant_index;
                r_last_grant <= w_grant_index;
            end else if (w_xfer) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign bus.out_valid_o  = r_out_valid;
    assign bus.out_data_o   = r_out_data;
    assign bus.out_sensor_o = r_out_sensor;
    assign pending_o        = r_pending;
    assign overrun_flags_o  = r_flags;
    assign overrun_count_o  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_lighthouse_sample_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_lighthouse_sample_arbiter
// Brief   : Directed scenario checks for the lighthouse sample arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lighthouse_sample_arbiter;
    import lighthouse_pkg::*;

    localparam int N  = 4;
    localparam int OW = 16;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable_i = 1'b0;
    logic          clear_i  = 1'b0;
    logic [N-1:0]  pending_o;
    logic [N-1:0]  overrun_flags_o;
    logic [OW-1:0] overrun_count_o;

    int n_pass  = 0;
    int n_total = 0;

    lighthouse_sample_arbiter_if #(.NUMBER_OF_SENSORS(N)) bus();

    lighthouse_sample_arbiter #(
        .NUMBER_OF_SENSORS (N),
        .OVR_WIDTH         (OW)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable_i        (enable_i),
        .clear_i         (clear_i),
        .bus             (bus.master),
        .pending_o       (pending_o),
        .overrun_flags_o (overrun_flags_o),
        .overrun_count_o (overrun_count_o)
    );

    always #10 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input int k, input logic [31:0] w);
        bus.sample_strobe_i[k]        = 1'b1;
        bus.sensor_data_i[32*k +: 32] = w;
    endtask

    task automatic idle_inputs();
        bus.sample_strobe_i = '0;
        bus.sensor_data_i   = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        bus.out_ready_i = 1'b0;
        enable_i = 1'b1;
        clear_i  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        bus.out_ready_i = 1'b1;
        step();
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid_o); else n_pass++;
        n_total++; if (bus.out_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", bus.out_data_o); else n_pass++;
        n_total++; if (bus.out_sensor_o !== 4'h0) $display("FAIL reset_sensor: got %h want 0", bus.out_sensor_o); else n_pass++;
        n_total++; if (pending_o !== 4'h0) $display("FAIL reset_pending: got %b want 0", pending_o); else n_pass++;
        n_total++; if (overrun_flags_o !== 4'h0) $display("FAIL reset_flags: got %b want 0", overrun_flags_o); else n_pass++;
        n_total++; if (overrun_count_o !== 16'h0) $display("FAIL reset_count: got %h want 0", overrun_count_o); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        bus.out_ready_i = 1'b1;
        strobe(2, 32'h2000_1234);
        step();
        idle_inputs();
        n_total++; if (pending_o !== 4'b0100) $display("FAIL single_pending: got %b want 0100", pending_o); else n_pass++;
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL single_early_valid: got %b want 0", bus.out_valid_o); else n_pass++;
        step();
        n_total++; if (bus.out_valid_o !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.out_valid_o); else n_pass++;
        n_total++; if (bus.out_data_o !== 32'h2000_1234) $display("FAIL single_data: got %h want 20001234", bus.out_data_o); else n_pass++;
        n_total++; if (bus.out_sensor_o !== 4'd2) $display("FAIL single_sensor: got %0d want 2", bus.out_sensor_o); else n_pass++;
        step();
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL single_drop: got %b want 0", bus.out_valid_o); else n_pass++;
    endtask

    task automatic test_four();
        do_reset();
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < N; k++) strobe(k, 32'h2000_0000 + k);
        step();
        idle_inputs();
        n_total++; if (pending_o !== 4'b1111) $display("FAIL four_pending: got %b want 1111", pending_o); else n_pass++;
        for (int k = 0; k < N; k++) begin
            step();
            n_total++; if (bus.out_valid_o !== 1'b1) $display("FAIL four_valid_%0d: got %b want 1", k, bus.out_valid_o); else n_pass++;
            n_total++; if (bus.out_sensor_o !== 4'(k)) $display("FAIL four_sensor_%0d: got %0d want %0d", k, bus.out_sensor_o, k); else n_pass++;
            n_total++; if (bus.out_data_o !== 32'h2000_0000 + k) $display("FAIL four_data_%0d: got %h want %h", k, bus.out_data_o, 32'h2000_0000 + k); else n_pass++;
        end
        step();
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL four_drop: got %b want 0", bus.out_valid_o); else n_pass++;
    endtask

    task automatic test_stall_overrun();
        do_reset();
        bus.out_ready_i = 1'b0;
        strobe(1, 32'h2000_000A);
        step();
        strobe(1, 32'h2000_000B);
        step();
        n_total++; if (bus.out_data_o !== 32'h2000_000A) $display("FAIL stall_first: got %h want 2000000a", bus.out_data_o); else n_pass++;
        n_total++; if (overrun_count_o !== 16'd0) $display("FAIL stall_no_ovr: got %0d want 0", overrun_count_o); else n_pass++;
        strobe(1, 32'h2000_000C);
        step();
        idle_inputs();
        n_total++; if (overrun_count_o !== 16'd1) $display("FAIL stall_count: got %0d want 1", overrun_count_o); else n_pass++;
        n_total++; if (overrun_flags_o !== 4'b0010) $display("FAIL stall_flags: got %b want 0010", overrun_flags_o); else n_pass++;
        n_total++; if (pending_o !== 4'b0010) $display("FAIL stall_pending: got %b want 0010", pending_o); else n_pass++;
        step();
        step();
        n_total++; if (bus.out_valid_o !== 1'b1) $display("FAIL stall_valid: got %b want 1", bus.out_valid_o); else n_pass++;
        n_total++; if (bus.out_data_o !== 32'h2000_000A) $display("FAIL stall_hold: got %h want 2000000a", bus.out_data_o); else n_pass++;
        n_total++; if (bus.out_sensor_o !== 4'd1) $display("FAIL stall_sensor: got %0d want 1", bus.out_sensor_o); else n_pass++;
        bus.out_ready_i = 1'b1;
        step();
        n_total++; if (bus.out_data_o !== 32'h2000_000C) $display("FAIL stall_second: got %h want 2000000c", bus.out_data_o); else n_pass++;
        n_total++; if (bus.out_valid_o !== 1'b1) $display("FAIL stall_second_valid: got %b want 1", bus.out_valid_o); else n_pass++;
        step();
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL stall_drain: got %b want 0", bus.out_valid_o); else n_pass++;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        n_total++; if (overrun_count_o !== 16'd0) $display("FAIL clear_count: got %0d want 0", overrun_count_o); else n_pass++;
        n_total++; if (overrun_flags_o !== 4'b0000) $display("FAIL clear_flags: got %b want 0000", overrun_flags_o); else n_pass++;
    endtask

    task automatic test_filtered();
        do_reset();
        bus.out_ready_i = 1'b1;
        strobe(0, 32'h0000_0055);
        step();
        idle_inputs();
        n_total++; if (pending_o !== 4'b0000) $display("FAIL filt_invalid_pending: got %b want 0000", pending_o); else n_pass++;
        step();
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL filt_invalid_out: got %b want 0", bus.out_valid_o); else n_pass++;
        enable_i = 1'b0;
        strobe(2, 32'h2000_0077);
        step();
        idle_inputs();
        enable_i = 1'b1;
        n_total++; if (pending_o !== 4'b0000) $display("FAIL filt_disabled_pending: got %b want 0000", pending_o); else n_pass++;
        step();
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL filt_disabled_out: got %b want 0", bus.out_valid_o); else n_pass++;
        n_total++; if (overrun_count_o !== 16'd0) $display("FAIL filt_count: got %0d want 0", overrun_count_o); else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.out_ready_i = 1'b0;
        strobe(1, 32'h2000_0011);
        step();
        idle_inputs();
        strobe(0, 32'h2000_0001);
        step();
        idle_inputs();
        n_total++; if (bus.out_sensor_o !== 4'd1) $display("FAIL same_setup_sensor: got %0d want 1", bus.out_sensor_o); else n_pass++;
        n_total++; if (pending_o !== 4'b0001) $display("FAIL same_setup_pending: got %b want 0001", pending_o); else n_pass++;
        bus.out_ready_i = 1'b1;
        strobe(0, 32'h2000_0002);
        step();
        idle_inputs();
        n_total++; if (bus.out_data_o !== 32'h2000_0001) $display("FAIL same_old_word: got %h want 20000001", bus.out_data_o); else n_pass++;
        n_total++; if (pending_o[0] !== 1'b1) $display("FAIL same_pending: got %b want 1", pending_o[0]); else n_pass++;
        n_total++; if (overrun_count_o !== 16'd0) $display("FAIL same_count: got %0d want 0", overrun_count_o); else n_pass++;
        step();
        n_total++; if (bus.out_data_o !== 32'h2000_0002) $display("FAIL same_new_word: got %h want 20000002", bus.out_data_o); else n_pass++;
        n_total++; if (bus.out_sensor_o !== 4'd0) $display("FAIL same_new_sensor: got %0d want 0", bus.out_sensor_o); else n_pass++;
        step();
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL same_drain: got %b want 0", bus.out_valid_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < N; k++) strobe(k, 32'h2000_00F0 + k);
        step();
        idle_inputs();
        step();
        n_total++; if (bus.out_valid_o !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid_o); else n_pass++;
        n_total++; if (pending_o !== 4'b1110) $display("FAIL mid_pre_pending: got %b want 1110", pending_o); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL mid_valid: got %b want 0", bus.out_valid_o); else n_pass++;
        n_total++; if (bus.out_data_o !== 32'h0) $display("FAIL mid_data: got %h want 0", bus.out_data_o); else n_pass++;
        n_total++; if (bus.out_sensor_o !== 4'h0) $display("FAIL mid_sensor: got %0d want 0", bus.out_sensor_o); else n_pass++;
        n_total++; if (pending_o !== 4'h0) $display("FAIL mid_pending: got %b want 0000", pending_o); else n_pass++;
        #2;
        reset_n = 1'b1;
        bus.out_ready_i = 1'b1;
        strobe(3, 32'h2000_0333);
        step();
        idle_inputs();
        n_total++; if (bus.out_valid_o !== 1'b0) $display("FAIL mid_post_early: got %b want 0", bus.out_valid_o); else n_pass++;
        n_total++; if (pending_o !== 4'b1000) $display("FAIL mid_post_pending: got %b want 1000", pending_o); else n_pass++;
        step();
        n_total++; if (bus.out_valid_o !== 1'b1) $display("FAIL mid_post_valid: got %b want 1", bus.out_valid_o); else n_pass++;
        n_total++; if (bus.out_data_o !== 32'h2000_0333) $display("FAIL mid_post_data: got %h want 20000333", bus.out_data_o); else n_pass++;
        n_total++; if (bus.out_sensor_o !== 4'd3) $display("FAIL mid_post_sensor: got %0d want 3", bus.out_sensor_o); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        bus.out_ready_i = 1'b0;
        test_reset();
        test_single();
        test_four();
        test_stall_overrun();
        test_filtered();
        test_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
